instr_encoder: RTL and testbench
================================

# instr_encoder

Streaming RISC-V instruction encoder, the inverse of the core's opcode decoder. It accepts symbolic commands (operation, register indices, immediate) over a valid/ready handshake. Each command is packed into a 32-bit RV32I word for the supported subset and written sequentially into instruction memory. It sits between the test/boot loader and the instruction memory write port, and lets benches and boot logic build programs without hand-assembled hex.

## Interface
- `ADDR_W`, 9, instruction memory word-address width.
- `BASE_ADDR`, 0, first word address written after reset or flush.

- `clk` in 1: single clock; all state changes on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted on edge where `cmd_valid & cmd_ready`.
- `cmd_op` in 3: 0 ADD, 1 AND, 2 ADDI, 3 LUI, 4 JAL, 5 LW, 6 SW, 7 BEQ.
- `cmd_rd`, `cmd_rs1`, `cmd_rs2` in 5 each: register indices; unused fields ignored.
- `cmd_imm` in 32: signed byte immediate. For LUI it is the full 32-bit value.
- `flush` in 1: synchronous; restart program at `BASE_ADDR`.
- `imem_we` out 1: write request.
- `imem_ready` in 1: memory takes the write on edge where `imem_we & imem_ready`.
- `imem_addr` out ADDR_W: word address.
- `imem_wdata` out 32: encoded instruction.
- `count` out ADDR_W+1: commands accepted since reset/flush.
- `full` out 1: `count == 2**ADDR_W`.
- `err` out 1: sticky immediate-range error.
- `err_clr` in 1: clears `err`.

## Operation
- Two-stage pipeline.
  - Stage A registers the accepted command and its assigned address (`BASE_ADDR + count`, modulo 2^ADDR_W).
  - Stage B holds the encoded word and drives `imem_*`.
- Stage B advances when empty or when `imem_ready` is high. Stage A advances into B under the same condition.
- `cmd_ready = !full & !flush & (A empty | A advancing)`. Full throughput is one word per cycle.
- Encodings, opcode / funct3 / funct7:
  - ADD: 0110011 / 000 / 0000000
  - AND: 0110011 / 111 / 0000000
  - ADDI: 0010011 / 000
  - LUI: 0110111
  - JAL: 1101111
  - LW: 0000011 / 010
  - SW: 0100011 / 010
  - BEQ: 1100011 / 000
- Immediate placement follows the RV32I I/S/B/U/J formats. For SW and BEQ, rd is not encoded; for I/U/J formats, rs2 is not encoded.
- Legal immediate ranges:
  - ADDI/LW/SW: −2048..2047.
  - BEQ: −4096..4094, even.
  - JAL: −1048576..1048574, even.
  - LUI: `imm[11:0]==0`.
- Out-of-range immediate: the word written is NOP `0x00000013` and `err` sets in the cycle the word enters stage B.
- `count` increments on every acceptance and saturates at 2^ADDR_W. While `full`, `cmd_ready` stays 0.
- `flush` empties stages A and B (a pending write is dropped), zeroes `count` and clears `full`. It does not clear `err`.
- `err_clr` clears `err`. If a new error occurs in the same cycle, set wins.
- Reset values: `cmd_ready` 0, `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `count` 0, `full` 0, `err` 0. `cmd_ready` goes to 1 in the first cycle after reset deassertion.
- Reset mid-operation: all in-flight commands are discarded immediately (asynchronous).

## Timing
- Command accepted at edge E0.
- `imem_we`=1, with its address and data, is visible after edge E1 when B is free.
- The write completes at the first edge with `imem_ready`=1.
- `imem_we`/`imem_addr`/`imem_wdata` hold stable while `imem_ready`=0.
- `flush` asserted in cycle C: `imem_we`=0 and `count`=0 after that edge. `cmd_ready` is 0 during C, and a command presented in C is not accepted.
- `full` rises in the same cycle `count` reaches 2^ADDR_W. Accepted words still drain.

## Configuration
- `INSTR_ENCODER_RANGE_CHECK_EN` defined: range checks, NOP substitution and `err` as described.
- Not defined: immediates are truncated to their field width without checks, the word is always encoded as given, and `err` is tied 0. `err_clr` is ignored.

## Test plan
- ADDI x1,x0,5 then ADD x3,x1,x2, with `imem_ready`=1 → words `0x00500093` @0 and `0x002081B3` @1, on consecutive cycles.
- LW x5,8(x2); SW x5,12(x2); LUI x4,0x12345000 → `0x00812283`, `0x00512623`, `0x12345237` at addresses 0,1,2.
- BEQ x1,x2,−4 and JAL x1,8 → `0xFE208EE3` and `0x008000EF`. ADDI with imm 2048 → `0x00000013` written, `err`=1 until `err_clr`.
- Hold `imem_ready`=0 for 5 cycles with commands streaming → `cmd_ready` drops after 2 accepted, `imem_*` stable. Release → no word lost or duplicated.
- ADDR_W=2: accept 4 commands → `count`=4, `full`=1, `cmd_ready`=0. Flush → next command is written at `BASE_ADDR`.
- Assert `reset_n`=0 while stage B holds an unwritten word → `imem_we` drops immediately. After release the first word goes to address 0.

Source files
------------

// File: rtl/instr_encoder.sv
// Streaming RV32I subset encoder: symbolic commands in, packed words written sequentially to imem.
// Optional immediate range checking (NOP substitution + sticky err) enabled by INSTR_ENCODER_RANGE_CHECK_EN.
module instr_encoder #(
  parameter int          ADDR_W    = 9,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [4:0]        cmd_rd,
  input  logic [4:0]        cmd_rs1,
  input  logic [4:0]        cmd_rs2,
  input  logic [31:0]       cmd_imm,
  input  logic              flush,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  input  logic              err_clr
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_ADDI = 3'd2;
  localparam logic [2:0] OP_LUI  = 3'd3;
  localparam logic [2:0] OP_JAL  = 3'd4;
  localparam logic [2:0] OP_LW   = 3'd5;
  localparam logic [2:0] OP_SW   = 3'd6;
  localparam logic [2:0] OP_BEQ  = 3'd7;

  localparam logic [31:0]     NOP      = 32'h0000_0013;
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(1) << ADDR_W;

  function automatic logic [31:0] encode(input logic [2:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [31:0] imm);
    logic [31:0] w;
    w = NOP;
    case (op)
      OP_ADD:  w = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      OP_AND:  w = {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
      OP_ADDI: w = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
      OP_LUI:  w = {imm[31:12], rd, 7'b0110111};
      OP_JAL:  w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      OP_LW:   w = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      OP_SW:   w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      OP_BEQ:  w = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
      default: w = NOP;
    endcase
    return w;
  endfunction

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  // An immediate fits a signed field when all bits above the field's sign bit match it.
  function automatic logic imm_bad(input logic [2:0] op, input logic [31:0] imm);
    logic bad;
    case (op)
      OP_ADDI, OP_LW, OP_SW: bad = !((&imm[31:11]) || !(|imm[31:11]));
      OP_BEQ:  bad = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      OP_JAL:  bad = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      OP_LUI:  bad = |imm[11:0];
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction
`endif

  logic              rdy_en_q;
  logic              a_vld_q, a_vld_d;
  logic [2:0]        a_op_q, a_op_d;
  logic [4:0]        a_rd_q, a_rd_d, a_rs1_q, a_rs1_d, a_rs2_q, a_rs2_d;
  logic [31:0]       a_imm_q, a_imm_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d;
  logic              b_vld_q, b_vld_d;
  logic [ADDR_W-1:0] b_addr_q, b_addr_d;
  logic [31:0]       b_data_q, b_data_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              b_adv, accept, a_bad;

  assign b_adv     = !b_vld_q || imem_ready;
  assign full      = (count_q == CNT_FULL);
  assign cmd_ready = rdy_en_q && !full && !flush && (!a_vld_q || b_adv);
  assign accept    = cmd_valid && cmd_ready;

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  assign a_bad = imm_bad(a_op_q, a_imm_q);
`else
  assign a_bad = 1'b0;
`endif

  always_comb begin
    a_vld_d  = a_vld_q;
    a_op_d   = a_op_q;
    a_rd_d   = a_rd_q;
    a_rs1_d  = a_rs1_q;
    a_rs2_d  = a_rs2_q;
    a_imm_d  = a_imm_q;
    a_addr_d = a_addr_q;
    b_vld_d  = b_vld_q;
    b_addr_d = b_addr_q;
    b_data_d = b_data_q;
    count_d  = count_q;
    err_d    = err_q && !err_clr;

    if (flush) begin
      a_vld_d = 1'b0;
      b_vld_d = 1'b0;
      count_d = '0;
    end else begin
      if (b_adv) begin
        b_vld_d = a_vld_q;
        if (a_vld_q) begin
          b_addr_d = a_addr_q;
          b_data_d = a_bad ? NOP : encode(a_op_q, a_rd_q, a_rs1_q, a_rs2_q, a_imm_q);
          err_d    = err_d || a_bad;
        end
      end
      // A is either empty or moving into B whenever a command is accepted.
      if (accept) begin
        a_vld_d  = 1'b1;
        a_op_d   = cmd_op;
        a_rd_d   = cmd_rd;
        a_rs1_d  = cmd_rs1;
        a_rs2_d  = cmd_rs2;
        a_imm_d  = cmd_imm;
        a_addr_d = ADDR_W'(BASE_ADDR) + count_q[ADDR_W-1:0];
        count_d  = count_q + 1'b1;
      end else if (b_adv) begin
        a_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_en_q <= 1'b0;
      a_vld_q  <= 1'b0;
      a_op_q   <= '0;
      a_rd_q   <= '0;
      a_rs1_q  <= '0;
      a_rs2_q  <= '0;
      a_imm_q  <= '0;
      a_addr_q <= '0;
      b_vld_q  <= 1'b0;
      b_addr_q <= '0;
      b_data_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      a_vld_q  <= a_vld_d;
      a_op_q   <= a_op_d;
      a_rd_q   <= a_rd_d;
      a_rs1_q  <= a_rs1_d;
      a_rs2_q  <= a_rs2_d;
      a_imm_q  <= a_imm_d;
      a_addr_q <= a_addr_d;
      b_vld_q  <= b_vld_d;
      b_addr_q <= b_addr_d;
      b_data_q <= b_data_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  assign imem_we    = b_vld_q;
  assign imem_addr  = b_addr_q;
  assign imem_wdata = b_data_q;
  assign count      = count_q;

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  assign err = err_q;
`else
  // Without range checks err never sets; err_clr has nothing to clear.
  logic unused_err;
  assign unused_err = err_q;
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (ADDR_W=2 so full/flush corners are cheap to reach).
module tb_instr_encoder;

  localparam int ADDR_W = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [2:0]        cmd_op = '0;
  logic [4:0]        cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
  logic [31:0]       cmd_imm = '0;
  logic              flush = 1'b0;
  logic              imem_we;
  logic              imem_ready = 1'b1;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;
  logic              err_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) u_dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .flush(flush), .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .count(count), .full(full), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [31:0] exp_w;
    logic        exp_err;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    cmd_valid = 1'b1;
  endtask

  // Called just after a posedge; returns just after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    int n;
    drive(op, rd, rs1, rs2, imm);
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: cmd_ready stuck at 0");
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic expect_write(input string nm, input int addr, input logic [31:0] data);
    int n;
    n = 0;
    @(negedge clk);
    while (!imem_we && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_we"}, 32'(imem_we), 32'd1);
    check({nm, "_addr"}, 32'(imem_addr), 32'(addr));
    check({nm, "_data"}, imem_wdata, data);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  initial begin
    int exp_cnt;
    vecs[0]  = '{3'd2, 5'd1, 5'd0, 5'd0, 32'd5,           32'h0050_0093, 1'b0};
    vecs[1]  = '{3'd0, 5'd3, 5'd1, 5'd2, 32'd0,           32'h0020_81B3, 1'b0};
    vecs[2]  = '{3'd5, 5'd5, 5'd2, 5'd0, 32'd8,           32'h0081_2283, 1'b0};
    vecs[3]  = '{3'd6, 5'd0, 5'd2, 5'd5, 32'd12,          32'h0051_2623, 1'b0};
    vecs[4]  = '{3'd3, 5'd4, 5'd0, 5'd0, 32'h1234_5000,   32'h1234_5237, 1'b0};
    vecs[5]  = '{3'd7, 5'd0, 5'd1, 5'd2, -32'sd4,         32'hFE20_8EE3, 1'b0};
    vecs[6]  = '{3'd4, 5'd1, 5'd0, 5'd0, 32'd8,           32'h0080_00EF, 1'b0};
    vecs[7]  = '{3'd1, 5'd7, 5'd6, 5'd5, 32'd0,           32'h0053_73B3, 1'b0};
    vecs[8]  = '{3'd2, 5'd2, 5'd1, 5'd0, -32'sd1,         32'hFFF0_8113, 1'b0};
    vecs[9]  = '{3'd2, 5'd1, 5'd0, 5'd0, 32'd2048,        CHK ? NOP : 32'h8000_0093, CHK};
    vecs[10] = '{3'd4, 5'd1, 5'd0, 5'd0, 32'd3,           CHK ? NOP : 32'h0020_00EF, CHK};
    vecs[11] = '{3'd3, 5'd1, 5'd0, 5'd0, 32'h0000_1001,   CHK ? NOP : 32'h0000_10B7, CHK};
    vecs[12] = '{3'd7, 5'd0, 5'd0, 5'd0, 32'd4096,        CHK ? NOP : 32'h8000_0063, CHK};
    vecs[13] = '{3'd6, 5'd0, 5'd0, 5'd0, -32'sd2048,      32'h8000_2023, 1'b0};
    vecs[14] = '{3'd7, 5'd0, 5'd0, 5'd0, 32'd4094,        32'h7E00_0FE3, 1'b0};
    vecs[15] = '{3'd4, 5'd0, 5'd0, 5'd0, 32'hFFF0_0000,   32'h8000_006F, 1'b0};

    // Reset values
    #12;
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk); reset_n = 1'b1; #1;
    check("rst_rel_ready0", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    check("rst_rel_ready1", 32'(cmd_ready), 32'd1);

    // Back-to-back: words on consecutive cycles, one cycle after the accepting edge
    send(3'd2, 5'd1, 5'd0, 5'd0, 32'd5);
    send(3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    @(negedge clk);
    check("b2b_we0", 32'(imem_we), 32'd1);
    check("b2b_addr0", 32'(imem_addr), 32'd0);
    check("b2b_data0", imem_wdata, 32'h0050_0093);
    @(negedge clk);
    check("b2b_we1", 32'(imem_we), 32'd1);
    check("b2b_addr1", 32'(imem_addr), 32'd1);
    check("b2b_data1", imem_wdata, 32'h0020_81B3);
    @(posedge clk); #1;
    pulse_flush();

    // Table vectors, flushing whenever the small memory fills
    exp_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      send(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      expect_write($sformatf("vec%0d", i), exp_cnt, vecs[i].exp_w);
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      exp_cnt++;
      check($sformatf("vec%0d_count", i), 32'(count), 32'(exp_cnt));
      @(posedge clk); #1;
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      check($sformatf("vec%0d_errclr", i), 32'(err), 32'd0);
      if (exp_cnt == 4) begin
        pulse_flush();
        exp_cnt = 0;
      end
    end
    pulse_flush();

    // Backpressure: two accepted, then stall with stable outputs, then drain in order
    imem_ready = 1'b0;
    send(3'd2, 5'd1, 5'd0, 5'd0, 32'd5);
    send(3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    drive(3'd1, 5'd7, 5'd6, 5'd5, 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp%0d_ready", k), 32'(cmd_ready), 32'd0);
      check($sformatf("bp%0d_we", k), 32'(imem_we), 32'd1);
      check($sformatf("bp%0d_addr", k), 32'(imem_addr), 32'd0);
      check($sformatf("bp%0d_data", k), imem_wdata, 32'h0050_0093);
      @(posedge clk); #1;
    end
    imem_ready = 1'b1;
    @(negedge clk);
    check("bp_rel_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("bp_w1_addr", 32'(imem_addr), 32'd1);
    check("bp_w1_data", imem_wdata, 32'h0020_81B3);
    @(negedge clk);
    check("bp_w2_addr", 32'(imem_addr), 32'd2);
    check("bp_w2_data", imem_wdata, 32'h0053_73B3);
    @(negedge clk);
    check("bp_drained_we", 32'(imem_we), 32'd0);
    check("bp_count", 32'(count), 32'd3);
    @(posedge clk); #1;
    pulse_flush();

    // Fill to full, confirm saturation, then flush with a command presented
    for (int k = 0; k < 4; k++) send(3'd2, 5'(k), 5'd0, 5'd0, 32'(k));
    drive(3'd2, 5'd9, 5'd0, 5'd0, 32'd9);
    @(negedge clk);
    check("full_count", 32'(count), 32'd4);
    check("full_flag", 32'(full), 32'd1);
    check("full_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("full_count_hold", 32'(count), 32'd4);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    cmd_valid = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_full", 32'(full), 32'd0);
    send(3'd2, 5'd2, 5'd1, 5'd0, -32'sd1);
    expect_write("after_flush", 0, 32'hFFF0_8113);
    @(posedge clk); #1;
    pulse_flush();

    // Flush drops a stalled write
    imem_ready = 1'b0;
    send(3'd2, 5'd1, 5'd0, 5'd0, 32'd5);
    @(negedge clk); @(negedge clk);
    check("drop_pre_we", 32'(imem_we), 32'd1);
    @(posedge clk); #1;
    pulse_flush();
    check("drop_we", 32'(imem_we), 32'd0);
    check("drop_count", 32'(count), 32'd0);
    imem_ready = 1'b1;
    send(3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    expect_write("drop_next", 0, 32'h0020_81B3);
    @(posedge clk); #1;
    pulse_flush();

    // Asynchronous reset while B holds an unwritten word
    imem_ready = 1'b0;
    send(3'd4, 5'd1, 5'd0, 5'd0, 32'd8);
    send(3'd5, 5'd5, 5'd2, 5'd0, 32'd8);
    @(negedge clk);
    check("arst_pre_we", 32'(imem_we), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_we", 32'(imem_we), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_ready", 32'(cmd_ready), 32'd0);
    check("arst_addr", 32'(imem_addr), 32'd0);
    imem_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    send(3'd3, 5'd4, 5'd0, 5'd0, 32'h1234_5000);
    expect_write("arst_next", 0, 32'h1234_5237);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
